// File: rtl/rx_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_shift : serial-to-parallel receive shifter, LSB first, ping-pong buffers |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rx_shift #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CSRX,
  input  logic             ShiftRX,
  input  logic             DIn,
  input  logic             Clear,
  input  logic             RXRead,
  output logic [WIDTH-1:0] RXOut,
  output logic             RXValid,
  output logic             RXBufSel,
  output logic [CNTW-1:0]  BitCnt,
  output logic             Overrun
);

  localparam logic [CNTW-1:0] C_LAST_BIT = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_BOTH  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNTW-1:0]  r_bitcnt;
  logic             r_overrun;
  logic [WIDTH-1:0] w_buf [2];

  logic w_clear;
  logic w_accept;
  logic w_drop;
  logic w_complete;
  logic w_read;

  // Occupancy is judged on the state at the start of the cycle, so a read on
  // the same edge never frees room for a bit arriving while both are full.
  assign w_clear    = CSRX & Clear;
  assign w_accept   = CSRX & ShiftRX & ~Clear & (r_state != S_BOTH);
  assign w_drop     = CSRX & ShiftRX & ~Clear & (r_state == S_BOTH);
  assign w_complete = w_accept & (r_bitcnt == C_LAST_BIT);
  assign w_read     = CSRX & RXRead & ~Clear & (r_state != S_EMPTY);

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_complete) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_complete && !w_read)      w_state_nxt = S_BOTH;
          else if (!w_complete && w_read) w_state_nxt = S_EMPTY;
        end
        S_BOTH:  if (w_read) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_bitcnt  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_wr_ptr  <= 1'b0;
        r_rd_ptr  <= 1'b0;
        r_bitcnt  <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_complete) begin
          r_wr_ptr <= ~r_wr_ptr;
          r_bitcnt <= '0;
        end else if (w_accept) begin
          r_bitcnt <= r_bitcnt + CNTW'(1);
        end
        if (w_read) r_rd_ptr <= ~r_rd_ptr;
        if (w_drop) r_overrun <= 1'b1;
      end
    end
  end

  // Buffer contents survive Clear; only reset zeroes them.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      logic [WIDTH-1:0] r_word;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word <= '0;
        end else if (w_accept && (r_wr_ptr == 1'(gi))) begin
          r_word[r_bitcnt] <= DIn;
        end
      end

      assign w_buf[gi] = r_word;
    end
  endgenerate

  assign RXOut    = r_rd_ptr ? w_buf[1] : w_buf[0];
  assign RXValid  = (r_state != S_EMPTY);
  assign RXBufSel = r_rd_ptr;
  assign BitCnt   = r_bitcnt;
  assign Overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rx_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rx_shift : randomized + directed self-checking bench for rx_shift        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_rx_shift;

  localparam int WIDTH = 32;
  localparam int CNTW  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             CSRX, ShiftRX, DIn, Clear, RXRead;
  logic [WIDTH-1:0] RXOut;
  logic             RXValid, RXBufSel, Overrun;
  logic [CNTW-1:0]  BitCnt;

  int checks = 0;
  int errors = 0;

  rx_shift #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .CSRX     (CSRX),
    .ShiftRX  (ShiftRX),
    .DIn      (DIn),
    .Clear    (Clear),
    .RXRead   (RXRead),
    .RXOut    (RXOut),
    .RXValid  (RXValid),
    .RXBufSel (RXBufSel),
    .BitCnt   (BitCnt),
    .Overrun  (Overrun)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of finished words plus the two buffer images.
  logic [WIDTH-1:0] m_buf [2];
  logic [WIDTH-1:0] m_q [$];
  int               m_pcnt;
  bit               m_wsel, m_rsel, m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_buf[0] = '0;
    m_buf[1] = '0;
    m_q.delete();
    m_pcnt = 0;
    m_wsel = 1'b0;
    m_rsel = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_step(input bit cs, input bit sh, input bit din, input bit clr, input bit rd);
    bit full_at_start, read_ok;
    if (!cs) return;
    if (clr) begin
      m_q.delete();
      m_pcnt = 0;
      m_wsel = 1'b0;
      m_rsel = 1'b0;
      m_ovr  = 1'b0;
      return;
    end
    full_at_start = (m_q.size() == 2);
    read_ok       = rd && (m_q.size() > 0);
    if (sh) begin
      if (full_at_start) begin
        m_ovr = 1'b1;
      end else begin
        m_buf[m_wsel][m_pcnt] = din;
        m_pcnt++;
        if (m_pcnt == WIDTH) begin
          m_q.push_back(m_buf[m_wsel]);
          m_pcnt = 0;
          m_wsel = ~m_wsel;
        end
      end
    end
    if (read_ok) begin
      void'(m_q.pop_front());
      m_rsel = ~m_rsel;
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] exp_out;
    exp_out = (m_q.size() > 0) ? m_q[0] : m_buf[m_rsel];
    chk("rxvalid",  32'(RXValid),  32'(m_q.size() > 0));
    chk("rxout",    RXOut,         exp_out);
    chk("rxbufsel", 32'(RXBufSel), 32'(m_rsel));
    chk("bitcnt",   32'(BitCnt),   32'(m_pcnt));
    chk("overrun",  32'(Overrun),  32'(m_ovr));
  endtask

  task automatic do_cycle(input bit cs, input bit sh, input bit din, input bit clr, input bit rd);
    CSRX = cs; ShiftRX = sh; DIn = din; Clear = clr; RXRead = rd;
    @(posedge clk);
    model_step(cs, sh, din, clr, rd);
    #1;
    check_all();
  endtask

  task automatic shift_bits(input logic [31:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) do_cycle(1'b1, 1'b1, w[i], 1'b0, 1'b0);
  endtask

  task automatic shift_word(input logic [31:0] w);
    shift_bits(w, 0, WIDTH);
  endtask

  initial begin
    rst_n = 1'b0; CSRX = 1'b0; ShiftRX = 1'b0; DIn = 1'b0; Clear = 1'b0; RXRead = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rxout",   RXOut,           32'h0);
    chk("rst_rxvalid", 32'(RXValid),    32'h0);
    chk("rst_bufsel",  32'(RXBufSel),   32'h0);
    chk("rst_bitcnt",  32'(BitCnt),     32'h0);
    chk("rst_overrun", 32'(Overrun),    32'h0);
    rst_n = 1'b1;

    // First word lands in buffer 0, read hands over to buffer 1
    shift_word(32'hA5A50F0F);
    chk("t1_valid",  32'(RXValid),  32'h1);
    chk("t1_out",    RXOut,         32'hA5A50F0F);
    chk("t1_bufsel", 32'(RXBufSel), 32'h0);
    chk("t1_bitcnt", 32'(BitCnt),   32'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_rd_valid",  32'(RXValid),  32'h0);
    chk("t1_rd_bufsel", 32'(RXBufSel), 32'h1);

    // Fill both buffers, then overrun
    shift_word(32'h11111111);
    shift_word(32'h22222222);
    chk("t2_out_first", RXOut, 32'h11111111);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_overrun", 32'(Overrun), 32'h1);
    chk("t2_bitcnt",  32'(BitCnt),  32'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_out_second", RXOut, 32'h22222222);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_drained", 32'(RXValid), 32'h0);

    // Completion into buffer 1 on the same edge as the read of buffer 0
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    shift_word(32'hDEADBEEF);
    shift_bits(32'hCAFEF00D, 0, WIDTH - 1);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t3_out",    RXOut,         32'hCAFEF00D);
    chk("t3_valid",  32'(RXValid),  32'h1);
    chk("t3_bufsel", 32'(RXBufSel), 32'h1);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_one_left", 32'(RXValid), 32'h0);

    // Partial word held while deselected
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    shift_bits(32'h13579BDF, 0, 10);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, i[0], 1'b1, 1'b0, ~i[0]);
    chk("t4_hold_bitcnt", 32'(BitCnt), 32'd10);
    shift_bits(32'h13579BDF, 10, 22);
    chk("t4_word", RXOut, 32'h13579BDF);

    // Asynchronous reset in the middle of a word
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    shift_bits(32'hFFFFFFFF, 0, 20);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_bitcnt",  32'(BitCnt),  32'h0);
    chk("t5_rst_valid",   32'(RXValid), 32'h0);
    chk("t5_rst_overrun", 32'(Overrun), 32'h0);
    #2 rst_n = 1'b1;
    shift_word(32'h0F1E2D3C);
    chk("t5_word", RXOut, 32'h0F1E2D3C);

    // Clear beats a simultaneous read after an overrun
    shift_word(32'h55AA55AA);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_overrun", 32'(Overrun), 32'h1);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_clr_overrun", 32'(Overrun),  32'h0);
    chk("t6_clr_valid",   32'(RXValid),  32'h0);
    chk("t6_clr_bufsel",  32'(RXBufSel), 32'h0);
    shift_word(32'h76543210);
    chk("t6_wrptr0_bufsel", 32'(RXBufSel), 32'h0);
    chk("t6_wrptr0_out",    RXOut,         32'h76543210);

    // Randomized traffic with varying read pressure
    for (int n = 0; n < 4000; n++) begin
      int rdp;
      bit cs, sh, din, clr, rd;
      case ((n / 400) % 3)
        0:       rdp = 2;
        1:       rdp = 30;
        default: rdp = 80;
      endcase
      cs  = ($urandom_range(99) < 90);
      sh  = ($urandom_range(99) < 85);
      din = 1'($urandom);
      clr = ($urandom_range(299) == 0);
      rd  = ($urandom_range(99) < rdp);
      do_cycle(cs, sh, din, clr, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_shift.md
Name: rx_shift

Overview:
- Serial-to-parallel receive shifter; mirror of the transmit shifter on the same link.
- Samples serial DIn one bit per enabled clk, LSB first, and assembles WIDTH-bit words into two ping-pong buffers.
- Presents completed words, oldest first, to the parallel side with a valid/read handshake.
- Flags overrun when both buffers hold unread words and more data arrives.

Parameters:
- WIDTH, 32, word length in bits; one word fills one buffer.
- CNTW, 5, bit-counter width; equals ceil(log2(WIDTH)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- CSRX  input  1  block select; when low, ShiftRX, RXRead and Clear are ignored and state holds.
- ShiftRX  input  1  sample enable; DIn is captured on this edge when high (and CSRX high).
- DIn  input  1  serial data in, LSB first.
- Clear  input  1  synchronous flush of pointers, flags, bit count and overrun; buffer data is not cleared.
- RXRead  input  1  consumer pop of the word currently on RXOut.
- RXOut  output  WIDTH  data of the buffer at the read pointer.
- RXValid  output  1  buffer at the read pointer is full.
- RXBufSel  output  1  index (0/1) of the buffer driving RXOut.
- BitCnt  output  CNTW  bits accepted into the word currently being assembled.
- Overrun  output  1  sticky flag: a bit was dropped because both buffers were full.

Behaviour:
- Reset (rst_n low, asynchronous): RXBuf0 = RXBuf1 = 0, full flags = 0, write pointer = 0, read pointer = 0, BitCnt = 0, Overrun = 0.
  - Outputs during reset: RXOut = 0, RXValid = 0, RXBufSel = 0.
  - Reset asserted mid-word discards the partial word.
- Occupancy FSM:
  - EMPTY: no full buffers.
  - ONE: one full buffer.
  - BOTH: two full buffers; read pointer equals write pointer.
  - Transitions: word completion moves EMPTY→ONE or ONE→BOTH. Accepted read moves BOTH→ONE or ONE→EMPTY. Completion plus read in the same cycle keeps ONE.
- Bit accept:
  - Condition: CSRX & ShiftRX, and the write buffer is not full at the start of the cycle.
  - Action: DIn is written to bit [BitCnt] of the write buffer, then BitCnt increments.
  - Result: first received bit lands at bit 0 (LSB first).
- Word completion:
  - Trigger: the accept that brings BitCnt from WIDTH-1 to WIDTH.
  - Same edge: BitCnt ← 0, write buffer full flag ← 1, write pointer toggles.
  - Latency: RXValid/RXOut reflect the new word immediately after that edge when that buffer is at the read pointer (zero extra cycles).
- Read:
  - RXRead & CSRX & RXValid at an edge clears the full flag of the read buffer and toggles the read pointer.
  - RXRead while RXValid = 0 is ignored; no pointer move, no error.
  - RXOut is held stable while RXValid = 1 and no read occurs.
- Overrun:
  - Trigger: CSRX & ShiftRX while in BOTH.
  - Effects: the bit is dropped, BitCnt does not advance, Overrun ← 1.
  - A read in the same cycle does not rescue the bit; the full check uses state at cycle start.
  - Overrun clears only on Clear or reset.
- Simultaneous events:
  - Completion and read of the other buffer in one cycle: both take effect.
  - Clear has priority over every other action in the same cycle.
- Partial words: no timeout; BitCnt and partial data hold indefinitely while ShiftRX is low or CSRX is low.
- Clear (with CSRX high): full flags, pointers, BitCnt and Overrun ← 0 next edge; RXValid drops to 0.

Test Plan:
- Reset, CSRX = 1, shift 0xA5A50F0F LSB first over 32 ShiftRX cycles → after 32nd edge: RXValid = 1, RXOut = 0xA5A50F0F, RXBufSel = 0, BitCnt = 0. Pulse RXRead → RXValid = 0, RXBufSel = 1.
- Shift 0x11111111 then 0x22222222 with no reads → BOTH. Then:
  - RXOut = 0x11111111.
  - One more ShiftRX bit → Overrun = 1, BitCnt stays 0.
  - RXRead → RXOut = 0x22222222.
  - RXRead again → RXValid = 0.
- Buffer 0 holds 0xDEADBEEF; while completing 0xCAFEF00D into buffer 1, assert RXRead on the completion edge → next cycle RXOut = 0xCAFEF00D, RXValid = 1, state ONE.
- Shift 10 bits of a word, drop CSRX for 5 cycles with ShiftRX and RXRead toggling → BitCnt holds 10. Resume for 22 bits → word completes with correct value.
- Shift 20 bits, pulse rst_n low for 3 ns mid-cycle → BitCnt = 0, RXValid = 0, Overrun = 0 immediately. The next 32 bits form a clean word.
- Create an overrun, then assert Clear with RXRead also high → next edge: Overrun = 0, RXValid = 0, both pointers 0.
